// File: rtl/chromatic_pkg.sv
// chromatic_pkg: pixel width and buffer state encoding shared by the display output path.
`timescale 1ns/1ps
package chromatic_pkg;
    localparam int RGB_W = 24;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
endpackage

// File: rtl/pixel_fifo_ram.sv
// pixel_fifo_ram: simple dual-port storage, synchronous write, asynchronous read.
`timescale 1ns/1ps
module pixel_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int W = 24
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/pixel_output_buffer.sv
// pixel_output_buffer: first-word-fall-through pixel FIFO between image_processor and display,
// with registered almost-full stall, sticky overflow and saturating drop counter.
`timescale 1ns/1ps
module pixel_output_buffer
    import chromatic_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RGB_W-1:0]           in_rgb,
    input  logic                       in_valid,
    output logic                       in_stall,
    output logic [RGB_W-1:0]           out_rgb,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [15:0]                drop_count,
    input  logic                       clr_status,
    output logic                       busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AFULL = AFULL_LEVEL[AW:0];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [RGB_W-1:0] rd_data;
    logic full, empty, pop, push, drop, to_empty;
    state_t state, state_next;
    assign level = wr_ptr - rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = !empty;
    assign out_rgb = out_valid ? rd_data : '0;
    assign pop = out_valid && out_ready;
    // When full, a same-cycle pop frees the slot the push overwrites (read happens before the edge).
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;
    assign busy = !empty || state != IDLE;
    assign to_empty = !push && (empty || (level == 1 && pop));
    pixel_fifo_ram #(.DEPTH(DEPTH), .W(RGB_W)) u_ram (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr[AW-1:0]),
        .wdata(in_rgb),
        .raddr(rd_ptr[AW-1:0]),
        .rdata(rd_data)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            in_stall <= 1'b0;
            overflow <= 1'b0;
            drop_count <= '0;
            state <= IDLE;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            in_stall <= level >= AFULL;
            if (clr_status) begin
                overflow <= 1'b0;
                drop_count <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                drop_count <= (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;
            end
            state <= state_next;
        end
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = push ? STREAM : IDLE;
            STREAM:  state_next = in_stall ? DRAIN : (to_empty ? IDLE : STREAM);
            DRAIN:   state_next = in_stall ? DRAIN : STREAM;
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pixel_output_buffer.sv
// tb_pixel_output_buffer: directed sequence with a queue scoreboard for pixel_output_buffer.
`timescale 1ns/1ps
module tb_pixel_output_buffer;
    import chromatic_pkg::*;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [23:0] in_rgb = '0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic clr_status = 1'b0;
    logic in_stall, out_valid, overflow, busy;
    logic [23:0] out_rgb;
    logic [4:0] level;
    logic [15:0] drop_count;
    int total = 0;
    int bad = 0;
    logic [23:0] q[$];
    int mdrop = 0;
    bit mov = 1'b0;
    bit mstall = 1'b0;

    pixel_output_buffer #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_rgb    (in_rgb),
        .in_valid  (in_valid),
        .in_stall  (in_stall),
        .out_rgb   (out_rgb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .drop_count(drop_count),
        .clr_status(clr_status),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check DUT against the scoreboard, then advance the model and the clock by one edge.
    task automatic cycle();
        bit nstall;
        chk("level", level, q.size());
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) chk("head", out_rgb, q[0]);
        if (q.size() > 0) chk("busy", busy, 1);
        chk("in_stall", in_stall, mstall);
        chk("overflow", overflow, mov);
        chk("drop_count", drop_count, mdrop);
        nstall = q.size() >= AFULL;
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && q.size() < DEPTH) q.push_back(in_rgb);
        else if (in_valid && !clr_status) begin
            mov = 1'b1;
            if (mdrop < 16'hFFFF) mdrop++;
        end
        if (clr_status) begin
            mov = 1'b0;
            mdrop = 0;
        end
        mstall = nstall;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_rgb", out_rgb, 0);
        chk("rst_level", level, 0);
        chk("rst_in_stall", in_stall, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single pixel, pushed on the first edge after reset release
        in_valid = 1'b1;
        in_rgb = 24'hFF8000;
        cycle();
        in_valid = 1'b0;
        chk("single_valid", out_valid, 1);
        chk("single_rgb", out_rgb, 24'hFF8000);
        chk("single_level", level, 1);
        cycle();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        cycle();

        // fill to full with consumer stalled, then one dropped push
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_rgb = 24'h000100 + 24'(i);
            cycle();
        end
        chk("fill_level", level, 16);
        chk("fill_stall", in_stall, 1);
        in_rgb = 24'h000BAD;
        cycle();
        in_valid = 1'b0;
        chk("drop_overflow", overflow, 1);
        chk("drop_count1", drop_count, 1);
        chk("drop_head", out_rgb, 24'h000100);
        cycle();

        // full FIFO, simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            out_ready = 1'b1;
            in_rgb = 24'h000200 + 24'(i);
            cycle();
        end
        chk("pp_level", level, 16);
        chk("pp_drop", drop_count, 1);

        // status clear on the same edge as a drop
        out_ready = 1'b0;
        clr_status = 1'b1;
        in_rgb = 24'h000BD2;
        cycle();
        clr_status = 1'b0;
        in_valid = 1'b0;
        chk("clr_overflow", overflow, 0);
        chk("clr_drop_count", drop_count, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() > 0; k++) cycle();
        out_ready = 1'b0;
        cycle();

        // streaming 0..39 with random backpressure; upstream honours in_stall
        for (int i = 0, g = 0; i < 40 && g < 2000; g++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (in_stall) in_valid = 1'b0;
            else begin
                in_valid = 1'b1;
                in_rgb = 24'(i);
                i++;
            end
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && q.size() > 0; k++) cycle();
        cycle();
        cycle();
        chk("stream_level", level, 0);
        chk("stream_busy", busy, 0);
        chk("stream_drops", drop_count, 0);
        chk("stream_stall", in_stall, 0);

        // reset in the middle of a stream
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_rgb = 24'h000700 + 24'(i);
            cycle();
        end
        in_valid = 1'b0;
        chk("pre_rst_level", level, 7);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_stall", in_stall, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rgb", out_rgb, 0);
        q.delete();
        mstall = 1'b0;
        mov = 1'b0;
        mdrop = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b1;
        in_rgb = 24'h123456;
        cycle();
        in_valid = 1'b0;
        chk("post_rst_head", out_rgb, 24'h123456);
        chk("post_rst_level", level, 1);
        out_ready = 1'b1;
        cycle();
        cycle();
        chk("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pixel_output_buffer.md
PIXEL_OUTPUT_BUFFER -- requirements
Module: pixel_output_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 4..256).
REQ-002 SHALL have parameter AFULL_LEVEL, default 12, occupancy at which in_stall asserts (1..DEPTH-1).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_rgb  input  24  processed pixel {R[23:16],G[15:8],B[7:0]} from image_processor.
REQ-006 SHALL have port in_valid  input  1  in_rgb valid this cycle; push request, no ready (upstream cannot be stalled mid-beat).
REQ-007 SHALL have port in_stall  output  1  occupancy >= AFULL_LEVEL; upstream stops issuing new pixels.
REQ-008 SHALL have port out_rgb  output  24  head-of-FIFO pixel to display side.
REQ-009 SHALL have port out_valid  output  1  out_rgb valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port overflow  output  1  sticky: a push was dropped.
REQ-013 SHALL have port drop_count  output  16  dropped pixels, saturating at 16'hFFFF.
REQ-014 SHALL have port clr_status  input  1  clears overflow and drop_count.
REQ-015 SHALL have port busy  output  1  high when level != 0 or state != IDLE.

Function
REQ-016 SHALL implement a first-word-fall-through FIFO: push on in_valid, pop on out_valid && out_ready.
REQ-017 SHALL make a pixel pushed at edge N visible on out_rgb/out_valid after edge N (one-cycle latency) when FIFO was empty.
REQ-018 SHALL hold out_rgb stable while out_valid && !out_ready.
REQ-019 SHALL, on simultaneous push and pop, accept both and keep level unchanged, including when level == DEPTH.
REQ-020 SHALL, on push with level == DEPTH and no pop, drop the pixel, leave FIFO contents unchanged, set overflow, increment drop_count (saturating).
REQ-021 SHALL ignore pops when empty (out_valid low); level never underflows.
REQ-022 SHALL wrap read/write pointers modulo DEPTH; full/empty derived from extra pointer MSB.
REQ-023 SHALL register in_stall: high the cycle after level reaches AFULL_LEVEL, low the cycle after level falls below it.
REQ-024 SHALL give clr_status priority over a same-cycle drop: overflow=0, drop_count=0 after that edge.
REQ-025 SHALL run state machine IDLE -> STREAM on first push; STREAM -> DRAIN when in_stall asserts; DRAIN -> STREAM when in_stall deasserts; STREAM -> IDLE when level becomes 0 with no push.
REQ-026 SHALL use state only for busy/stall reporting; data path behaviour SHALL be identical in all states.

Reset
REQ-027 SHALL, while rst is high, force out_valid=0, out_rgb=24'h0, in_stall=0, level=0, overflow=0, drop_count=0, busy=0, pointers=0, state=IDLE.
REQ-028 SHALL discard all buffered pixels on reset asserted mid-stream; storage RAM contents need no reset.
REQ-029 SHALL accept no push on the first edge after rst deasserts only if in_valid is low; a push on that edge SHALL be accepted normally.

Structure
REQ-030 SHALL take RGB_W (24) and the state enum (IDLE, STREAM, DRAIN) from shared package chromatic_pkg.
REQ-031 SHALL instantiate one sub-module pixel_fifo_ram (simple dual-port, sync write, async or FWFT-registered read, DEPTH x RGB_W).

Verification
REQ-032 SHALL test single push 24'hFF8000 into empty FIFO -> out_valid=1 and out_rgb=24'hFF8000 one cycle later, level=1.
REQ-033 SHALL test 16 pushes with out_ready=0 -> level=16, in_stall high from cycle after 12th push; 17th push -> overflow=1, drop_count=1, head still first pixel.
REQ-034 SHALL test full FIFO with simultaneous push/pop for 8 cycles -> level stays 16, no drop, output order preserved.
REQ-035 SHALL test pushes 0..39 with random out_ready -> received sequence 0..39 in order when no overflow, level returns to 0, busy=0, state IDLE.
REQ-036 SHALL test rst pulse at level=7 -> next cycle out_valid=0, level=0, in_stall=0; subsequent push 24'h123456 emerges first.
REQ-037 SHALL test clr_status coincident with a drop -> overflow=0, drop_count=0 after the edge.
